score_bcd_arbiter: RTL and testbench
====================================

Name: score_bcd_arbiter

Overview:
- Shares one sequential (shift-and-add-3) binary-to-BCD converter between two requesters: requester 0 = score, requester 1 = countdown timer.
- Each requester holds a registered BCD result that feeds the downstream BCD-to-7-segment decoders.
- Replaces per-source combinational converters with one multi-cycle datapath.
- Request/acknowledge handshake with round-robin arbitration.

Parameters:
- WIDTH, 8: binary input width.
- DIGITS, 3: BCD digits per result. Must satisfy 10^DIGITS > 2^WIDTH - 1. Out-of-range values are not supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  2  conversion request, one bit per requester. Level; held until ack.
- value0  input  WIDTH  binary value of requester 0. Sampled on the grant edge only.
- value1  input  WIDTH  binary value of requester 1. Sampled on the grant edge only.
- ack  output  2  one-cycle completion pulse per requester.
- busy  output  1  high while a conversion is in progress.
- bcd0  output  4*DIGITS  requester 0 result. Digit k is bits [4k+3:4k]; k=0 is the ones digit.
- bcd1  output  4*DIGITS  requester 1 result.
- blank0  output  DIGITS  leading-zero flags for bcd0 (see Optional Feature).
- blank1  output  DIGITS  leading-zero flags for bcd1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ack=0, busy=0, bcd0=bcd1=0, blank0=blank1=0, shift counter=0, round-robin pointer set so requester 0 wins the first tie. A reset mid-conversion aborts it: no ack, and results keep their reset value.
- All outputs are registered.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Effective requests = req with the bit of any currently-high ack masked.
  - If neither bit is set, stay in IDLE.
  - If exactly one bit is set, grant it.
  - If both are set, grant the requester not served last.
  - On the grant edge: capture that requester's value into the shift register, clear the BCD working register, record the owner, counter=0, go to SHIFT.
- SHIFT, one bit per cycle, MSB first:
  - Every working digit >= 5 gets +3 (4-bit add, no carry out).
  - Then shift the whole {BCD, binary} register left by 1.
  - counter increments; after WIDTH SHIFT cycles go to DONE.
- DONE (1 cycle):
  - At its exiting edge, load the working BCD into the owner's bcd register, set ack[owner]=1 for exactly one cycle, update the round-robin pointer, go to IDLE.
- Latency: req sampled at edge E0 -> ack and new bcdN visible after edge E0+WIDTH+1 (E9 at defaults). busy high after E0 until E9.
- Throughput: next grant no earlier than E10, i.e. one conversion per WIDTH+2 cycles.
- Non-owner's bcd register never changes during another conversion.
- Owner deasserting req mid-conversion: conversion still completes, result is stored, ack still pulses.
- req or value changes after the grant edge: ignored for the current conversion.
- Requester re-asserting req right after its ack while the other is waiting: the other requester is granted (round robin).
- Input 0 -> all-zero BCD. Input 2^WIDTH-1 -> correct full-scale value (255 -> 2,5,5).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - blankN is registered alongside bcdN (same edge).
  - Bit k=1 iff digit k and every higher digit are 0, for k >= 1.
  - Bit 0 is always 0, so the ones digit is never blanked.
  - Downstream drives all segments off for blanked digits.
- Undefined: blank0 and blank1 are tied to 0; no extra logic.

Test Plan:
- Reset, then req=01, value0=8'd255 -> ack=01 for one cycle 9 edges after the grant; bcd0=12'h255; busy high for 9 cycles; bcd1 stays 0.
- req=11 from IDLE, value0=8'd42, value1=8'd7 -> requester 0 served first (bcd0=12'h042), then requester 1 (bcd1=12'h007); second ack arrives 10 edges after the first.
- Requester 0 holds req through its ack while requester 1 pending, value1=8'd100 -> requester 1 granted next, bcd1=12'h100; no duplicate conversion for requester 0 on the ack cycle.
- value0=8'd0, then 8'd9, then 8'd10 -> bcd0 = 12'h000, 12'h009, 12'h010. With LEADING_ZERO_BLANK_EN: blank0 = 3'b110, 3'b110, 3'b100.
- rst_n pulsed low during SHIFT of value0=8'd200 -> outputs clear immediately, no ack; after release, a fresh req converts 200 -> 12'h200.
- value0 changed from 8'd50 to 8'd99 one cycle after the grant -> bcd0=12'h050.

Source files
------------

// File: rtl/score_bcd_arbiter.sv
// -----------------------------------------------------------------------------
// score_bcd_arbiter
//
// One sequential shift-and-add-3 binary-to-BCD converter shared by two
// requesters (0 = score, 1 = countdown timer). Each requester owns a
// registered BCD result that feeds its BCD-to-7-segment decoders. Requests
// use a level req / one-cycle ack handshake with round-robin arbitration.
// A conversion takes WIDTH+2 cycles: grant, WIDTH shift cycles, done.
//
// Parameters:
//   WIDTH   binary input width (default 8)
//   DIGITS  BCD digits per result; 10**DIGITS must exceed 2**WIDTH-1
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   req[1:0]        level request per requester, held until ack
//   value0, value1  binary value per requester, sampled on the grant edge
//   ack[1:0]        one-cycle completion pulse per requester
//   busy            high while a conversion is in progress
//   bcd0, bcd1      BCD result per requester, digit k at [4k+3:4k]
//   blank0, blank1  leading-zero flags per result (bit 0 always 0)
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   -> blankN registered alongside bcdN
//   undefined -> blankN tied to zero
// -----------------------------------------------------------------------------
module score_bcd_arbiter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [WIDTH-1:0]    value0,
    input  logic [WIDTH-1:0]    value1,
    output logic [1:0]          ack,
    output logic                busy,
    output logic [4*DIGITS-1:0] bcd0,
    output logic [4*DIGITS-1:0] bcd1,
    output logic [DIGITS-1:0]   blank0,
    output logic [DIGITS-1:0]   blank1
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [BW-1:0]    work;        // BCD half of the working register
    logic [BW-1:0]    work_adj;    // work after the add-3 correction
    logic [WIDTH-1:0] bin;         // binary half, shifted out MSB first
    logic [CW-1:0]    count;
    logic             owner;       // requester of the running conversion
    logic             last;        // requester served most recently
    logic [1:0]       eff_req;
    logic             grant;
    logic             grant_idx;
    logic             last_shift;

    // A requester whose ack is high this cycle is still holding req from
    // the finished conversion; masking it prevents a duplicate grant.
    assign eff_req    = req & ~ack;
    assign last_shift = (count == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    // Next-state and grant decode
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_next = state;
        grant      = 1'b0;
        grant_idx  = 1'b0;
        case (state)
            IDLE: begin
                if (eff_req != 2'b00) begin
                    grant      = 1'b1;
                    // On a tie the requester not served last wins.
                    grant_idx  = (eff_req == 2'b11) ? ~last : eff_req[1];
                    state_next = SHIFT;
                end
            end
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction: any digit >= 5 would become >= 10 after doubling.
    always_comb begin
        work_adj = work;
        for (int d = 0; d < DIGITS; d++) begin
            if (work[4*d +: 4] >= 4'd5)
                work_adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
        end
    end

    // Datapath, handshake and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            bin   <= '0;
            count <= '0;
            owner <= 1'b0;
            last  <= 1'b1;   // requester 0 wins the first tie
            ack   <= 2'b00;
            busy  <= 1'b0;
            bcd0  <= '0;
            bcd1  <= '0;
        end else begin
            ack <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant) begin
                        bin   <= grant_idx ? value1 : value0;
                        work  <= '0;
                        owner <= grant_idx;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    work  <= {work_adj[BW-2:0], bin[WIDTH-1]};
                    bin   <= {bin[WIDTH-2:0], 1'b0};
                    count <= count + CW'(1);
                end
                DONE: begin
                    if (owner) bcd1 <= work;
                    else       bcd0 <= work;
                    ack[owner] <= 1'b1;
                    last       <= owner;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_work;

    // Digit k (k >= 1) is blank when it and every higher digit are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_work = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above && (work[4*k +: 4] == 4'd0);
            blank_work[k] = zero_above;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank0 <= '0;
            blank1 <= '0;
        end else if (state == DONE) begin
            if (owner) blank1 <= blank_work;
            else       blank0 <= blank_work;
        end
    end
`else
    assign blank0 = '0;
    assign blank1 = '0;
`endif

endmodule

// File: tb/tb_score_bcd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_score_bcd_arbiter
//
// Directed and randomized checks of score_bcd_arbiter at WIDTH=8, DIGITS=3.
// Expected results come from decimal arithmetic on the input values and a
// round-robin "last served" record kept here.
// -----------------------------------------------------------------------------
module tb_score_bcd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [7:0]  value0, value1;
    logic [1:0]  ack;
    logic        busy;
    logic [11:0] bcd0, bcd1;
    logic [2:0]  blank0, blank1;

    int checks = 0;
    int errors = 0;

    // Reference state: value last stored per requester and last served.
    int exp_val[2];
    int last_srv;

    score_bcd_arbiter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .value0 (value0),
        .value1 (value1),
        .ack    (ack),
        .busy   (busy),
        .bcd0   (bcd0),
        .bcd1   (bcd1),
        .blank0 (blank0),
        .blank1 (blank1)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] to_blank(input int v);
`ifdef LEADING_ZERO_BLANK_EN
        return {v < 100, v < 10, 1'b0};
`else
        return 3'b000 + 3'(v & 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until ack rises (bounded). Reports edges taken, the ack seen and
    // how many of the sampled cycles before it had busy high.
    task automatic wait_ack(output int edges, output logic [1:0] a, output int busy_hi);
        edges   = 0;
        a       = 2'b00;
        busy_hi = 0;
        while (edges < 40) begin
            step();
            edges++;
            if (ack != 2'b00) begin
                a = ack;
                break;
            end
            if (busy) busy_hi++;
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_bcd0"},   32'(bcd0),   32'(to_bcd(exp_val[0])));
        check({tag, "_bcd1"},   32'(bcd1),   32'(to_bcd(exp_val[1])));
        check({tag, "_blank0"}, 32'(blank0), 32'(to_blank(exp_val[0])));
        check({tag, "_blank1"}, 32'(blank1), 32'(to_blank(exp_val[1])));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        step();
        step();
        rst_n = 1'b1;
        exp_val[0] = 0;
        exp_val[1] = 0;
        last_srv   = 1;
        step();
    endtask

    // Single-requester conversion from IDLE with the full latency check.
    task automatic convert(input string tag, input int idx, input int val);
        int edges, bh;
        logic [1:0] a;
        if (idx == 0) value0 = 8'(val);
        else          value1 = 8'(val);
        req[idx] = 1'b1;
        wait_ack(edges, a, bh);
        req[idx] = 1'b0;
        check({tag, "_latency"}, 32'(edges), 32'd10);
        check({tag, "_ack"}, 32'(a), 32'(2'b01 << idx));
        exp_val[idx] = val;
        last_srv     = idx;
        check_results(tag);
        step();
        check({tag, "_ack_pulse"}, 32'(ack), 32'd0);
    endtask

    initial begin
        int edges, bh, seen;
        logic [1:0] a;

        rst_n  = 1'b0;
        req    = 2'b00;
        value0 = 8'd0;
        value1 = 8'd0;
        exp_val[0] = 0;
        exp_val[1] = 0;
        last_srv   = 1;
        step();
        step();
        check("rst_ack",  32'(ack),  32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_results("rst");
        rst_n = 1'b1;
        step();

        // Full scale on requester 0, with busy window and ack timing.
        value0 = 8'd255;
        req    = 2'b01;
        step();
        check("fs_busy_after_grant", 32'(busy), 32'd1);
        wait_ack(edges, a, bh);
        req = 2'b00;
        check("fs_ack_edges", 32'(edges), 32'd9);
        check("fs_ack",       32'(a),     32'd1);
        check("fs_busy_cycles", 32'(bh + 1), 32'd9);
        check("fs_busy_end",  32'(busy),  32'd0);
        exp_val[0] = 255;
        last_srv   = 0;
        check_results("fs");
        step();
        check("fs_ack_pulse", 32'(ack), 32'd0);

        // Simultaneous requests from a fresh reset: 0 first, then 1.
        do_reset();
        value0 = 8'd42;
        value1 = 8'd7;
        req    = 2'b11;
        wait_ack(edges, a, bh);
        req[0] = 1'b0;
        check("tie_first_edges", 32'(edges), 32'd10);
        check("tie_first_ack",   32'(a),     32'd1);
        exp_val[0] = 42;
        last_srv   = 0;
        check_results("tie_first");
        wait_ack(edges, a, bh);
        req[1] = 1'b0;
        check("tie_second_edges", 32'(edges), 32'd10);
        check("tie_second_ack",   32'(a),     32'd2);
        exp_val[1] = 7;
        last_srv   = 1;
        check_results("tie_second");
        step();

        // Requester 0 keeps req high through its ack; 1 must be granted next.
        value0 = 8'd3;
        value1 = 8'd100;
        req    = 2'b11;
        wait_ack(edges, a, bh);
        check("hold_first_ack", 32'(a), 32'd1);
        exp_val[0] = 3;
        last_srv   = 0;
        wait_ack(edges, a, bh);
        req = 2'b00;
        check("hold_second_edges", 32'(edges), 32'd10);
        check("hold_second_ack",   32'(a),     32'd2);
        exp_val[1] = 100;
        last_srv   = 1;
        check_results("hold");
        step();
        step();
        check("hold_idle_busy", 32'(busy), 32'd0);

        // Small values and leading-zero flags.
        convert("zero", 0, 0);
        convert("nine", 0, 9);
        convert("ten",  0, 10);

        // Reset in the middle of a conversion.
        value0 = 8'd200;
        req    = 2'b01;
        step();
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_ack",  32'(ack),  32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bcd0", 32'(bcd0), 32'd0);
        check("midrst_blank0", 32'(blank0), 32'd0);
        req = 2'b00;
        exp_val[0] = 0;
        exp_val[1] = 0;
        last_srv   = 1;
        step();
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ack != 2'b00) seen = 1;
        end
        check("midrst_no_ack", 32'(seen), 32'd0);
        convert("after_rst", 0, 200);

        // Value change after the grant edge is ignored.
        value0 = 8'd50;
        req    = 2'b01;
        step();
        value0 = 8'd99;
        wait_ack(edges, a, bh);
        req = 2'b00;
        check("late_val_edges", 32'(edges), 32'd9);
        check("late_val_ack",   32'(a),     32'd1);
        exp_val[0] = 50;
        last_srv   = 0;
        check_results("late_val");
        step();

        // Randomized patterns against the decimal / round-robin model.
        for (int it = 0; it < 24; it++) begin
            int pat, first, second, v[2];
            pat  = int'($urandom_range(1, 3));
            v[0] = int'($urandom_range(0, 255));
            v[1] = int'($urandom_range(0, 255));
            value0 = 8'(v[0]);
            value1 = 8'(v[1]);
            if (pat == 3) first = (last_srv == 0) ? 1 : 0;
            else          first = (pat == 1) ? 0 : 1;
            second = 1 - first;
            req = 2'(pat);
            wait_ack(edges, a, bh);
            req[first] = 1'b0;
            check("rnd_first_edges", 32'(edges), 32'd10);
            check("rnd_first_ack",   32'(a),     32'(2'b01 << first));
            exp_val[first] = v[first];
            last_srv       = first;
            check_results("rnd_first");
            if (pat == 3) begin
                wait_ack(edges, a, bh);
                req[second] = 1'b0;
                check("rnd_second_edges", 32'(edges), 32'd10);
                check("rnd_second_ack",   32'(a),     32'(2'b01 << second));
                exp_val[second] = v[second];
                last_srv        = second;
                check_results("rnd_second");
            end
            step();
            check("rnd_ack_pulse", 32'(ack), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
